// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg: FSM state type and id-width helper for sub_share_arbiter (SUB_ARB_SAT_EN selects saturating diff)
package sub_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} sub_arb_state_t;
  function automatic int id_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction
endpackage

// File: rtl/N_bit_substractor.sv
// N_bit_substractor: unsigned a-b with borrow out on carry_out
module N_bit_substractor #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         carry_out
);
  assign {carry_out, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin picker, first set request at or above ptr with wrap
module rr_grant #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    any = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (!any && req[(int'(ptr) + i) % R]) begin
        any = 1'b1;
        gnt[(int'(ptr) + i) % R] = 1'b1;
        gnt_id = IDW'((int'(ptr) + i) % R);
      end
    end
  end
endmodule

// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: round-robin sharing of one subtractor among R requesters (SUB_ARB_SAT_EN clamps diff to 0 on borrow)
module sub_share_arbiter
  import sub_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4,
  localparam int IDW = id_width(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [N-1:0]   rsp_diff,
  output logic           rsp_borrow,
  input  logic           rsp_ready
);
  sub_arb_state_t state, state_nx;
  logic [IDW-1:0] ptr, op_id, gnt_id;
  logic [N-1:0] op_a, op_b, diff;
  logic [R-1:0] gnt;
  logic any, borrow;
  rr_grant #(.R(R), .IDW(IDW)) u_grant (
    .req(req_valid), .ptr(ptr), .gnt(gnt), .gnt_id(gnt_id), .any(any)
  );
  N_bit_substractor #(.N(N)) u_sub (
    .a(op_a), .b(op_b), .diff(diff), .carry_out(borrow)
  );
  // gated by rst so a requester never sees an accept that reset would discard
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  always_comb begin
    state_nx = (state == IDLE) ? (any ? EXEC : IDLE) :
               (state == EXEC) ? RESP :
               (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_diff <= '0;
      rsp_borrow <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_id <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        op_a <= req_a[int'(gnt_id)*N +: N];
        op_b <= req_b[int'(gnt_id)*N +: N];
        op_id <= gnt_id;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id <= op_id;
`ifdef SUB_ARB_SAT_EN
        rsp_diff <= borrow ? '0 : diff;
`else
        rsp_diff <= diff;
`endif
        rsp_borrow <= borrow;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        ptr <= (op_id == IDW'(R-1)) ? '0 : op_id + IDW'(1);
      end
    end
  end
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb_sub_share_arbiter: directed scoreboard bench for sub_share_arbiter with N=8, R=4
module tb_sub_share_arbiter;
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_a, req_b;
  logic [3:0] req_ready;
  logic rsp_valid, rsp_borrow;
  logic [1:0] rsp_id;
  logic [7:0] rsp_diff;
  logic [7:0] a_arr [4];
  logic [7:0] b_arr [4];
  typedef struct {logic [1:0] id; logic [7:0] diff; logic borrow;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  for (genvar i = 0; i < 4; i++) begin : g_pk
    assign req_a[i*8 +: 8] = a_arr[i];
    assign req_b[i*8 +: 8] = b_arr[i];
  end

  sub_share_arbiter #(.N(8), .R(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_diff(rsp_diff), .rsp_borrow(rsp_borrow), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.id = 2'(id);
    e.borrow = a < b;
    e.diff = a - b;
`ifdef SUB_ARB_SAT_EN
    if (e.borrow) e.diff = 8'h00;
`endif
    return e;
  endfunction

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  // called at a negedge; waits for grant, checks it, then checks the response
  task automatic serve(input string tag, input logic [3:0] exp_gnt, input bit drop, input int bp);
    int n = 0;
    int idx = 0;
    exp_t e;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, 32'(req_ready), 32'(exp_gnt));
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) idx = i;
    q.push_back(model(idx, a_arr[idx], b_arr[idx]));
    if (drop) begin
      drive();
      req_valid[idx] = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'd2);
    e = q.pop_front();
    chk({tag, "_id"}, 32'(rsp_id), 32'(e.id));
    chk({tag, "_diff"}, 32'(rsp_diff), 32'(e.diff));
    chk({tag, "_borrow"}, 32'(rsp_borrow), 32'(e.borrow));
    if (bp > 0) begin
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        chk({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_bp_diff"}, 32'(rsp_diff), 32'(e.diff));
        chk({tag, "_bp_id"}, 32'(rsp_id), 32'(e.id));
        chk({tag, "_bp_noready"}, 32'(req_ready), 32'd0);
      end
      drive();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_accept_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_accept_noready"}, 32'(req_ready), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 8'h11 * 8'(i + 1);
      b_arr[i] = 8'h01;
    end
    req_valid = 4'hF;
    repeat (2) drive();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_diff", 32'(rsp_diff), 32'd0);
    chk("rst_rsp_borrow", 32'(rsp_borrow), 32'd0);
    drive();
    rst = 1'b0;
    req_valid = 4'b0;
    drive();
    a_arr[0] = 8'h50; b_arr[0] = 8'h20;
    req_valid = 4'b0001;
    @(negedge clk);
    serve("single", 4'b0001, 1'b1, 0);
    drive();
    a_arr[2] = 8'h00; b_arr[2] = 8'h01;
    req_valid = 4'b0100;
    @(negedge clk);
    serve("wrap", 4'b0100, 1'b1, 0);
    drive();
    a_arr[3] = 8'h7F; b_arr[3] = 8'h80;
    a_arr[1] = 8'hC8; b_arr[1] = 8'h08;
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    @(negedge clk);
    serve("bp", 4'b1000, 1'b1, 5);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b0010);
    serve("after_bp", 4'b0010, 1'b1, 0);
    drive();
    a_arr[2] = 8'h44; b_arr[2] = 8'h22;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("midrst_grant", 32'(req_ready), 32'b0100);
    drive();
    req_valid = 4'b0;
    rst = 1'b1;
    drive();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    drive();
    a_arr[0] = 8'h90; b_arr[0] = 8'h10;
    a_arr[1] = 8'h33; b_arr[1] = 8'h33;
    a_arr[2] = 8'h05; b_arr[2] = 8'h80;
    a_arr[3] = 8'hFF; b_arr[3] = 8'h01;
    req_valid = 4'hF;
    @(negedge clk);
    serve("rr0", 4'b0001, 1'b0, 0);
    @(negedge clk);
    serve("rr1", 4'b0010, 1'b0, 0);
    @(negedge clk);
    serve("rr2", 4'b0100, 1'b0, 0);
    @(negedge clk);
    serve("rr3", 4'b1000, 1'b0, 0);
    @(negedge clk);
    serve("rr4", 4'b0001, 1'b1, 0);
    req_valid = 4'b0;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
